// File: rtl/aes_cmac.sv
// AES-128 CMAC engine: authenticates a BRAM-resident message, one AES round per cycle.
// Optional macro AES_CMAC_TRACE_EN exposes the chain value on `encrypted` after every AES operation.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module aes_cmac #(
    parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  len,
    input  logic [127:0] messIn,
    input  logic [127:0] cmacIn,
    output logic [127:0] encrypted,
    output logic         cmacDone,
    output logic [8:0]   messAddra,
    output logic [8:0]   cmacAddra
);
    typedef enum logic [2:0] {INIT, SUBKEY, BLOCK, LAST, DONE} state_t;

    state_t state, state_n;

    logic [3:0]   rnd;        // 0 = load, 1..10 = rounds, 11 = result ready
    logic [127:0] aes_st;
    logic [127:0] rk;
    logic [7:0]   rcon;
    logic [127:0] chain;
    logic [127:0] k1, k2;
    logic [9:0]   nblk;
    logic [8:0]   blk_idx;
    logic [3:0]   rbytes;
    logic         full_last;

    logic [9:0]   n_raw, n_calc, n_m1;
    logic         op_end, last_blk;
    logic [127:0] aes_in, pad, mprime;
    logic [127:0] sr, mc, round_out;
    logic [7:0]   sb [16];
    logic [31:0]  rot, ks_sub, ks_tmp;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] rk_next;
    logic         unused_len_bits;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] dbl(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Only whole bytes count; the low three length bits never matter.
    assign unused_len_bits = ^len[2:0];

    assign n_raw  = {1'b0, len[15:7]} + {9'd0, (len[6:3] != 4'd0)};
    assign n_calc = (n_raw == 10'd0) ? 10'd1 : n_raw;
    assign n_m1   = n_calc - 10'd1;

    assign op_end   = (rnd == 4'd11);
    assign last_blk = (({1'b0, blk_idx} + 10'd2) == nblk);

    // Round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (.a(aes_st[127-8*g -: 8]), .y(sb[g]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
        end
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    // On-the-fly key schedule
    assign rot = {rk[23:0], rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_ksbox
        aes_sbox u_ksbox (.a(rot[31-8*g -: 8]), .y(ks_sub[31-8*g -: 8]));
    end

    assign ks_tmp  = ks_sub ^ {rcon, 24'h0};
    assign w0n     = rk[127:96] ^ ks_tmp;
    assign w1n     = rk[95:64] ^ w0n;
    assign w2n     = rk[63:32] ^ w1n;
    assign w3n     = rk[31:0] ^ w2n;
    assign rk_next = {w0n, w1n, w2n, w3n};

    assign round_out = ((rnd == 4'd10) ? sr : mc) ^ rk_next;

    // Last-block formatting: keep r bytes, then 0x80, then zeros
    for (genvar j = 0; j < 16; j++) begin : g_pad
        assign pad[127-8*j -: 8] = (4'(j) < rbytes) ? cmacIn[127-8*j -: 8] :
                                   (4'(j) == rbytes) ? 8'h80 : 8'h00;
    end

    assign mprime = full_last ? (cmacIn ^ k1) : (pad ^ k2);

    always_comb begin
        aes_in = '0;
        case (state)
            BLOCK:   aes_in = chain ^ messIn;
            LAST:    aes_in = chain ^ mprime;
            default: aes_in = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            INIT:    state_n = SUBKEY;
            SUBKEY:  if (op_end) state_n = (nblk == 10'd1) ? LAST : BLOCK;
            BLOCK:   if (op_end && last_blk) state_n = LAST;
            LAST:    if (op_end) state_n = DONE;
            DONE:    state_n = DONE;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd       <= '0;
            aes_st    <= '0;
            rk        <= '0;
            rcon      <= '0;
            chain     <= '0;
            k1        <= '0;
            k2        <= '0;
            nblk      <= '0;
            blk_idx   <= '0;
            rbytes    <= '0;
            full_last <= 1'b0;
            encrypted <= '0;
            cmacDone  <= 1'b0;
            messAddra <= '0;
            cmacAddra <= '0;
        end else begin
            case (state)
                INIT: begin
                    nblk      <= n_calc;
                    rbytes    <= len[6:3];
                    full_last <= (len[15:3] != 13'd0) && (len[6:3] == 4'd0);
                    cmacAddra <= n_m1[8:0];
                    messAddra <= '0;
                    blk_idx   <= '0;
                    chain     <= '0;
                    rnd       <= '0;
                end
                SUBKEY, BLOCK, LAST: begin
                    if (rnd == 4'd0) begin
                        aes_st <= aes_in ^ KEY;
                        rk     <= KEY;
                        rcon   <= 8'h01;
                        rnd    <= 4'd1;
                    end else if (!op_end) begin
                        aes_st <= round_out;
                        rk     <= rk_next;
                        rcon   <= xtime(rcon);
                        rnd    <= rnd + 4'd1;
                    end else begin
                        rnd <= 4'd0;
                    end

                    // Next word is fetched while this block's rounds run.
                    if (state == BLOCK && rnd == 4'd1 && !last_blk)
                        messAddra <= messAddra + 9'd1;

                    if (op_end) begin
                        if (state == SUBKEY) begin
                            k1 <= dbl(aes_st);
                            k2 <= dbl(dbl(aes_st));
                        end else begin
                            chain <= aes_st;
                        end
                        if (state == BLOCK) blk_idx <= blk_idx + 9'd1;
                        if (state == LAST) cmacDone <= 1'b1;
`ifdef AES_CMAC_TRACE_EN
                        encrypted <= aes_st;
`else
                        if (state == LAST) encrypted <= aes_st;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_cmac.sv
// Self-checking bench for aes_cmac: RFC 4493 vectors plus random messages against a software CMAC.
// Honours AES_CMAC_TRACE_EN when checking the value shown after the subkey phase.

module tb_aes_cmac;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int MAX_EDGES = 4000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  len = '0;
    logic [127:0] messIn = '0;
    logic [127:0] cmacIn = '0;
    logic [127:0] encrypted;
    logic         cmacDone;
    logic [8:0]   messAddra;
    logic [8:0]   cmacAddra;

    logic [127:0] mem [512];
    logic [7:0]   sbox_t [256];
    int n_checks = 0;
    int n_fail = 0;

    aes_cmac #(.KEY(KEY)) dut (
        .clk(clk), .reset(reset), .len(len), .messIn(messIn), .cmacIn(cmacIn),
        .encrypted(encrypted), .cmacDone(cmacDone), .messAddra(messAddra), .cmacAddra(cmacAddra)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM model: one cycle read latency on each port
    always @(posedge clk) begin
        messIn <= mem[messAddra];
        cmacIn <= mem[cmacAddra];
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from the GF(2^8) inverse and the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int round = 1; round <= 10; round++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (round < 10) begin
                    s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
                    s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*round+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(4*c+r) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] dbl_ref(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic int blocks_of(input int nbytes);
        int n = (nbytes + 15) / 16;
        return (n == 0) ? 1 : n;
    endfunction

    // RFC 4493 over the first nbytes bytes of the memory image
    function automatic logic [127:0] cmac_ref(input int nbytes);
        logic [127:0] l, k1, k2, c, lastb;
        int n, idx;
        bit full;
        l  = aes_ref(KEY, 128'h0);
        k1 = dbl_ref(l);
        k2 = dbl_ref(k1);
        n = blocks_of(nbytes);
        full = (nbytes != 0) && (nbytes % 16 == 0);
        c = '0;
        for (int i = 0; i < n - 1; i++) c = aes_ref(KEY, c ^ mem[i]);
        for (int j = 0; j < 16; j++) begin
            idx = 16 * (n - 1) + j;
            if (idx < nbytes)       lastb[127-8*j -: 8] = mem[idx/16][127-8*(idx%16) -: 8];
            else if (idx == nbytes) lastb[127-8*j -: 8] = 8'h80;
            else                    lastb[127-8*j -: 8] = 8'h00;
        end
        lastb = lastb ^ (full ? k1 : k2);
        return aes_ref(KEY, c ^ lastb);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic fill_rfc();
        fill_random();
        mem[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        mem[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        mem[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        mem[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    endtask

    // One reset edge, then run until cmacDone or the edge budget runs out
    task automatic do_run(input logic [15:0] l, input bit scramble_len,
                          output int edges, output logic [127:0] tag, output int max_ma);
        reset = 1'b1;
        len = l;
        @(posedge clk);
        #1;
        reset = 1'b0;
        edges = 0;
        max_ma = 0;
        while (edges < MAX_EDGES) begin
            @(posedge clk);
            edges++;
            #1;
            if (int'(messAddra) > max_ma) max_ma = int'(messAddra);
            if (edges == 1 && scramble_len) len = 16'($urandom);
            if (cmacDone) break;
        end
        tag = encrypted;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        len = 16'hffff;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (encrypted !== 128'h0) begin n_fail++; $display("FAIL reset_encrypted: got %h expected 0", encrypted); end
        n_checks++; if (cmacDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", cmacDone); end
        n_checks++; if (messAddra !== 9'd0) begin n_fail++; $display("FAIL reset_messaddr: got %0d expected 0", messAddra); end
        n_checks++; if (cmacAddra !== 9'd0) begin n_fail++; $display("FAIL reset_cmacaddr: got %0d expected 0", cmacAddra); end
    endtask

    task automatic test_subkey();
        logic [127:0] exp_enc;
`ifdef AES_CMAC_TRACE_EN
        exp_enc = 128'h7df76b0c1ab899b33e42f047b91b546f;
`else
        exp_enc = 128'h0;
`endif
        fill_random();
        reset = 1'b1;
        len = 16'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        n_checks++; if (encrypted !== exp_enc) begin n_fail++; $display("FAIL subkey_encrypted: got %h expected %h", encrypted, exp_enc); end
        n_checks++; if (dut.k1 !== 128'hfbeed618357133667c85e08f7236a8de) begin n_fail++; $display("FAIL subkey_k1: got %h expected fbeed618357133667c85e08f7236a8de", dut.k1); end
        n_checks++; if (dut.k2 !== 128'hf7ddac306ae266ccf90bc11ee46d513b) begin n_fail++; $display("FAIL subkey_k2: got %h expected f7ddac306ae266ccf90bc11ee46d513b", dut.k2); end
        n_checks++; if (cmacDone !== 1'b0) begin n_fail++; $display("FAIL subkey_done_early: got %b expected 0", cmacDone); end
    endtask

    task automatic test_rfc_vectors();
        logic [15:0]  lens [4]  = '{16'd0, 16'd128, 16'd320, 16'd512};
        logic [127:0] tags [4]  = '{128'hbb1d6929e95937287fa37d129b756746,
                                    128'h070a16b46b4d4144f79bdd9dd04a287c,
                                    128'hdfa66747de9ae63030ca32611497c827,
                                    128'h51f0bebf7e3b9d92fc49741779363cfe};
        int           lat  [4]  = '{25, 25, 49, 61};
        int edges, max_ma;
        logic [127:0] tag;
        for (int k = 0; k < 4; k++) begin
            fill_rfc();
            do_run(lens[k], 1'b0, edges, tag, max_ma);
            n_checks++; if (tag !== tags[k]) begin n_fail++; $display("FAIL rfc_tag len=%0d: got %h expected %h", lens[k], tag, tags[k]); end
            n_checks++; if (edges !== lat[k]) begin n_fail++; $display("FAIL rfc_latency len=%0d: got %0d expected %0d", lens[k], edges, lat[k]); end
        end
        // Tag and done hold while length and memory keep changing
        for (int k = 0; k < 4; k++) begin
            len = 16'($urandom);
            mem[0] = {$urandom, $urandom, $urandom, $urandom};
            mem[3] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            n_checks++; if (cmacDone !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b expected 1", cmacDone); end
            n_checks++; if (encrypted !== tags[3]) begin n_fail++; $display("FAIL hold_tag: got %h expected %h", encrypted, tags[3]); end
        end
    endtask

    task automatic test_random();
        int nbits, nbytes, n, edges, max_ma;
        logic [127:0] tag, exp_tag;
        for (int k = 0; k < 6; k++) begin
            fill_random();
            nbits = (k == 0) ? 2048 : (k == 1) ? 135 : $urandom_range(8, 3000);
            nbytes = nbits / 8;
            n = blocks_of(nbytes);
            exp_tag = cmac_ref(nbytes);
            do_run(16'(nbits), 1'b1, edges, tag, max_ma);
            n_checks++; if (tag !== exp_tag) begin n_fail++; $display("FAIL random_tag len=%0d: got %h expected %h", nbits, tag, exp_tag); end
            n_checks++; if (edges !== 1 + 12 * (n + 1)) begin n_fail++; $display("FAIL random_latency len=%0d: got %0d expected %0d", nbits, edges, 1 + 12 * (n + 1)); end
            n_checks++; if (max_ma !== ((n >= 2) ? n - 2 : 0)) begin n_fail++; $display("FAIL random_sweep len=%0d: got %0d expected %0d", nbits, max_ma, (n >= 2) ? n - 2 : 0); end
            n_checks++; if (int'(cmacAddra) !== n - 1) begin n_fail++; $display("FAIL random_lastaddr len=%0d: got %0d expected %0d", nbits, cmacAddra, n - 1); end
        end
    endtask

    task automatic test_long();
        int edges, max_ma;
        logic [127:0] tag, exp_tag;
        fill_random();
        exp_tag = cmac_ref(34176 / 8);
        do_run(16'd34176, 1'b0, edges, tag, max_ma);
        n_checks++; if (tag !== exp_tag) begin n_fail++; $display("FAIL long_tag: got %h expected %h", tag, exp_tag); end
        n_checks++; if (edges !== 3217) begin n_fail++; $display("FAIL long_latency: got %0d expected 3217", edges); end
        n_checks++; if (max_ma !== 265) begin n_fail++; $display("FAIL long_sweep: got %0d expected 265", max_ma); end
        n_checks++; if (cmacAddra !== 9'd266) begin n_fail++; $display("FAIL long_lastaddr: got %0d expected 266", cmacAddra); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmacDone !== 1'b1 || encrypted !== exp_tag) begin n_fail++; $display("FAIL long_hold: got done=%b tag=%h expected done=1 tag=%h", cmacDone, encrypted, exp_tag); end
    endtask

    task automatic test_reset_midrun();
        int edges, max_ma;
        logic [127:0] tag, exp_tag;
        fill_random();
        exp_tag = cmac_ref(128);
        reset = 1'b1;
        len = 16'd1024;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (77) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (encrypted !== 128'h0) begin n_fail++; $display("FAIL midrun_encrypted: got %h expected 0", encrypted); end
        n_checks++; if (cmacDone !== 1'b0) begin n_fail++; $display("FAIL midrun_done: got %b expected 0", cmacDone); end
        n_checks++; if (messAddra !== 9'd0) begin n_fail++; $display("FAIL midrun_messaddr: got %0d expected 0", messAddra); end
        n_checks++; if (cmacAddra !== 9'd0) begin n_fail++; $display("FAIL midrun_cmacaddr: got %0d expected 0", cmacAddra); end
        do_run(16'd1024, 1'b0, edges, tag, max_ma);
        n_checks++; if (tag !== exp_tag) begin n_fail++; $display("FAIL midrun_tag: got %h expected %h", tag, exp_tag); end
        n_checks++; if (edges !== 109) begin n_fail++; $display("FAIL midrun_latency: got %0d expected 109", edges); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        for (int i = 0; i < 512; i++) mem[i] = '0;
        test_reset();
        test_subkey();
        test_rfc_vectors();
        test_random();
        test_long();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
